// File: rtl/color_pkg.sv
// color_pkg
// Shared definitions for everything that touches the 128-entry RGB444 color
// ROM: index/data widths, their typedefs, channel helpers used by the ROM,
// the renderers and the VGA output, and the grant-source enum used by the
// color ROM arbiter.
// No ports (package).
package color_pkg;

    localparam int COLOR_ADDR_W = 7;
    localparam int COLOR_DATA_W = 12;

    typedef logic [COLOR_ADDR_W-1:0] color_addr_t;
    typedef logic [COLOR_DATA_W-1:0] color_t;
    typedef logic [3:0]              channel_t;

    // Which rule produced this cycle's grant; the priority order is the enum order.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_STARVE,
        SRC_HIPRI,
        SRC_RR
    } grant_src_e;

    function automatic channel_t rgb_red(input color_t c);
        return c[11:8];
    endfunction

    function automatic channel_t rgb_green(input color_t c);
        return c[7:4];
    endfunction

    function automatic channel_t rgb_blue(input color_t c);
        return c[3:0];
    endfunction

    function automatic color_t rgb_pack(input channel_t r, input channel_t g, input channel_t b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/color_rom_arbiter_rr_pick.sv
// rr_pick
// Purely combinational round-robin picker: grants the first set bit of req at
// or after position ptr, wrapping modulo WIDTH. Reusable by any shared-resource
// arbiter.
// Ports:
//   req   in  WIDTH  request vector
//   ptr   in  PTR_W  search start position (values >= WIDTH wrap)
//   grant out WIDTH  one-hot grant, all-zero when req is empty
module rr_pick #(
    parameter int WIDTH = 4,
    parameter int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [WIDTH-1:0] grant
);

    logic found;

    // Walk the request vector starting at ptr; the first hit wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            if (!found && req[(int'(ptr) + k) % WIDTH]) begin
                grant[(int'(ptr) + k) % WIDTH] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/color_rom_arbiter.sv
// color_rom_arbiter
// Shares the single color ROM (7-bit index, 12-bit RGB444, 1-cycle registered
// read) between NUM_REQ requesters. One index is granted per cycle: a starved
// requester first, then the optional high-priority port, then round-robin.
// Each returned color is routed to its owner one cycle after the handshake.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   req_valid   in  per-requester request valid
//   req_addr    in  packed indices, requester i at [7i+6:7i]
//   req_ready   out one-hot grant (handshake = valid & ready)
//   rsp_valid   out one-hot owner of rsp_data this cycle
//   rsp_data    out color returned by the ROM
//   rom_addr    out index to the ROM (0 when nothing is granted)
//   rom_data    in  ROM read data
//   starve_evt  out strobe in the cycle a starvation grant is made
module color_rom_arbiter
    import color_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int HIPRI_EN     = 1,
    parameter int HIPRI_IDX    = 0,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*COLOR_ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output color_t                          rsp_data,
    output color_addr_t                     rom_addr,
    input  color_t                          rom_data,
    output logic                            starve_evt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
    localparam logic [NUM_REQ-1:0] HIPRI_MASK =
        (HIPRI_EN != 0) ? (NUM_REQ'(1) << HIPRI_IDX) : '0;

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] resp_tag_q, resp_tag_d;
    logic [7:0]         wait_cnt_q [NUM_REQ];
    logic [7:0]         wait_cnt_d [NUM_REQ];

    logic [NUM_REQ-1:0] starve_grant;
    logic [NUM_REQ-1:0] rr_req;
    logic [NUM_REQ-1:0] rr_grant;
    logic [NUM_REQ-1:0] grant;
    grant_src_e         grant_src;

    // The high-priority port never takes part in the round-robin search.
    assign rr_req = req_valid & ~HIPRI_MASK;

    rr_pick #(
        .WIDTH (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req   (rr_req),
        .ptr   (rr_ptr_q),
        .grant (rr_grant)
    );

    // Lowest-index starved requester; scanning downward lets the lowest hit win.
    always_comb begin
        starve_grant = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && !HIPRI_MASK[i] && wait_cnt_q[i] == LIMIT) begin
                starve_grant    = '0;
                starve_grant[i] = 1'b1;
            end
        end
    end

    // Priority resolution; nothing is granted while reset is held.
    always_comb begin
        grant_src = SRC_NONE;
        if (!reset) begin
            if (|starve_grant) begin
                grant_src = SRC_STARVE;
            end else if (|(req_valid & HIPRI_MASK)) begin
                grant_src = SRC_HIPRI;
            end else if (|rr_grant) begin
                grant_src = SRC_RR;
            end
        end
    end

    always_comb begin
        case (grant_src)
            SRC_STARVE: grant = starve_grant;
            SRC_HIPRI:  grant = req_valid & HIPRI_MASK;
            SRC_RR:     grant = rr_grant;
            default:    grant = '0;
        endcase
    end

    // Steer the granted index to the ROM; an idle cycle presents index 0.
    always_comb begin
        rom_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                rom_addr = req_addr[i*COLOR_ADDR_W +: COLOR_ADDR_W];
            end
        end
    end

    assign req_ready  = grant;
    assign starve_evt = (grant_src == SRC_STARVE);
    // A response in flight when reset arrives is suppressed immediately.
    assign rsp_valid  = reset ? '0 : resp_tag_q;
    assign rsp_data   = rom_data;

    // Next state: only round-robin grants advance the pointer; wait counters
    // saturate while a request loses and clear on grant or when it goes idle.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_src == SRC_RR) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rr_grant[i]) begin
                    rr_ptr_d = PTR_W'((i + 1) % NUM_REQ);
                end
            end
        end
        resp_tag_d = grant;
        for (int i = 0; i < NUM_REQ; i++) begin
            wait_cnt_d[i] = 8'd0;
            if (!HIPRI_MASK[i] && req_valid[i] && !grant[i]) begin
                wait_cnt_d[i] = (wait_cnt_q[i] >= LIMIT) ? LIMIT : wait_cnt_q[i] + 8'd1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            resp_tag_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt_q[i] <= 8'd0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            resp_tag_q <= resp_tag_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt_q[i] <= wait_cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_color_rom_arbiter.sv
// tb_color_rom_arbiter
// Directed bench for color_rom_arbiter (4 requesters, requester 0 high
// priority, starvation limit 3) driving a behavioural 1-cycle color ROM,
// followed by a random run checking grant/response invariants.
module tb_color_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  reqValid;
    logic [27:0] reqAddr;
    logic [3:0]  reqReady;
    logic [3:0]  rspValid;
    logic [11:0] rspData;
    logic [6:0]  romAddr;
    logic [11:0] romData;
    logic        starveEvt;

    int          cmpCount = 0;
    int          errCount = 0;
    logic [3:0]  prevReady;
    logic [6:0]  prevAddr;
    logic [3:0]  rndValid;

    logic [3:0]  expReady [4] = '{4'b0100, 4'b1000, 4'b0010, 4'b0100};
    logic [3:0]  expRsp   [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};
    logic [11:0] expData  [4] = '{12'h2FC, 12'hF12, 12'h0F4, 12'h2FC};

    always #5 clk = ~clk;

    color_rom_arbiter #(
        .NUM_REQ      (4),
        .HIPRI_EN     (1),
        .HIPRI_IDX    (0),
        .STARVE_LIMIT (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (reqValid),
        .req_addr   (reqAddr),
        .req_ready  (reqReady),
        .rsp_valid  (rspValid),
        .rsp_data   (rspData),
        .rom_addr   (romAddr),
        .rom_data   (romData),
        .starve_evt (starveEvt)
    );

    // Known ROM contents for the indices the directed vectors use; all else is black.
    function automatic logic [11:0] romLookup(input logic [6:0] a);
        case (a)
            7'd0:    return 12'h0F4;
            7'd1:    return 12'h5A5;
            7'd9:    return 12'h082;
            7'd35:   return 12'hF12;
            7'd64:   return 12'h2FC;
            default: return 12'h000;
        endcase
    endfunction

    // Behavioural ROM with one cycle of read latency.
    always @(posedge clk) begin
        romData <= romLookup(romAddr);
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        cmpCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Remember the grant of the cycle just ending, then drive the next cycle.
    task automatic applyStimulus(input logic rst, input logic [3:0] v,
                                 input logic [6:0] a0, input logic [6:0] a1,
                                 input logic [6:0] a2, input logic [6:0] a3);
        prevReady = reqReady;
        prevAddr  = romAddr;
        @(posedge clk);
        #1;
        reset    = rst;
        reqValid = v;
        reqAddr  = {a3, a2, a1, a0};
        #2;
    endtask

    initial begin
        reset    = 1'b1;
        reqValid = '0;
        reqAddr  = '0;

        // Reset: requests are ignored and every output is quiet.
        applyStimulus(1'b1, 4'b0010, 7'd0, 7'd9, 7'd0, 7'd0);
        checkOutput("rstReady", 32'(reqReady), 32'h0);
        checkOutput("rstRsp", 32'(rspValid), 32'h0);
        checkOutput("rstRomAddr", 32'(romAddr), 32'h0);
        checkOutput("rstStarve", 32'(starveEvt), 32'h0);
        applyStimulus(1'b1, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
        applyStimulus(1'b0, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
        checkOutput("postRstReady", 32'(reqReady), 32'h0);
        checkOutput("postRstRsp", 32'(rspValid), 32'h0);
        checkOutput("postRstRomAddr", 32'(romAddr), 32'h0);

        // Single request from requester 1, index 9.
        applyStimulus(1'b0, 4'b0010, 7'd0, 7'd9, 7'd0, 7'd0);
        checkOutput("singleReady", 32'(reqReady), 32'h2);
        checkOutput("singleRomAddr", 32'(romAddr), 32'd9);
        applyStimulus(1'b0, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
        checkOutput("singleRsp", 32'(rspValid), 32'h2);
        checkOutput("singleData", 32'(rspData), 32'h082);
        checkOutput("idleRomAddr", 32'(romAddr), 32'h0);
        checkOutput("idleReady", 32'(reqReady), 32'h0);

        // Grant index 1, then reset: response dropped, pointer back to 0.
        applyStimulus(1'b0, 4'b0010, 7'd0, 7'd1, 7'd0, 7'd0);
        checkOutput("preRstReady", 32'(reqReady), 32'h2);
        checkOutput("preRstRomAddr", 32'(romAddr), 32'd1);
        applyStimulus(1'b1, 4'b1110, 7'd0, 7'd64, 7'd35, 7'd0);
        checkOutput("midRstReady", 32'(reqReady), 32'h0);
        checkOutput("midRstRsp", 32'(rspValid), 32'h0);
        applyStimulus(1'b0, 4'b1110, 7'd0, 7'd64, 7'd35, 7'd0);
        checkOutput("afterRstRsp", 32'(rspValid), 32'h0);
        checkOutput("afterRstReady", 32'(reqReady), 32'h2);
        checkOutput("afterRstRomAddr", 32'(romAddr), 32'd64);

        // Round-robin rotation among 1, 2, 3.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 4'b1110, 7'd0, 7'd64, 7'd35, 7'd0);
            checkOutput($sformatf("rotReady%0d", k), 32'(reqReady), 32'(expReady[k]));
            checkOutput($sformatf("rotRsp%0d", k), 32'(rspValid), 32'(expRsp[k]));
            checkOutput($sformatf("rotData%0d", k), 32'(rspData), 32'(expData[k]));
            checkOutput($sformatf("rotStarve%0d", k), 32'(starveEvt), 32'h0);
        end
        applyStimulus(1'b0, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
        checkOutput("rotTailRsp", 32'(rspValid), 32'h4);
        checkOutput("rotTailData", 32'(rspData), 32'hF12);

        // High priority requester 0 holds the ROM until requester 2 starves.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 4'b0101, 7'd1, 7'd0, 7'd35, 7'd0);
            checkOutput($sformatf("hipriReady%0d", k), 32'(reqReady), 32'h1);
            checkOutput($sformatf("hipriStarve%0d", k), 32'(starveEvt), 32'h0);
            if (k > 0) begin
                checkOutput($sformatf("hipriRsp%0d", k), 32'(rspValid), 32'h1);
                checkOutput($sformatf("hipriData%0d", k), 32'(rspData), 32'h5A5);
            end
        end
        applyStimulus(1'b0, 4'b0101, 7'd1, 7'd0, 7'd35, 7'd0);
        checkOutput("starveReady", 32'(reqReady), 32'h4);
        checkOutput("starveEvt", 32'(starveEvt), 32'h1);
        checkOutput("starveRomAddr", 32'(romAddr), 32'd35);
        applyStimulus(1'b0, 4'b0101, 7'd1, 7'd0, 7'd35, 7'd0);
        checkOutput("resumeReady", 32'(reqReady), 32'h1);
        checkOutput("resumeStarve", 32'(starveEvt), 32'h0);
        checkOutput("starveRsp", 32'(rspValid), 32'h4);
        checkOutput("starveData", 32'(rspData), 32'hF12);
        applyStimulus(1'b0, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);

        // Unused index still produces a valid (black) response.
        applyStimulus(1'b0, 4'b1000, 7'd0, 7'd0, 7'd0, 7'd5);
        checkOutput("unusedReady", 32'(reqReady), 32'h8);
        checkOutput("unusedRomAddr", 32'(romAddr), 32'd5);
        applyStimulus(1'b0, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
        checkOutput("unusedRsp", 32'(rspValid), 32'h8);
        checkOutput("unusedData", 32'(rspData), 32'h000);

        // Random traffic: grants one-hot and valid-only, responses follow grants.
        for (int n = 0; n < 1000; n++) begin
            rndValid = 4'($urandom_range(0, 15));
            applyStimulus(1'b0, rndValid,
                          7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
                          7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
            checkOutput("rndOneHot", 32'($countones(reqReady) <= 1), 32'h1);
            checkOutput("rndSubset", 32'(reqReady & ~rndValid), 32'h0);
            checkOutput("rndRsp", 32'(rspValid), 32'(prevReady));
            if (prevReady != 4'b0000) begin
                checkOutput("rndData", 32'(rspData), 32'(romLookup(prevAddr)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
